// File: rtl/vga_text_pkg.sv
// Shared definitions for the vga_text character console.
// Contents: VRAM port widths, the control bytes the console interprets,
// the controller state encoding and a printable-byte test.
package vga_text_pkg;

    localparam int VRAM_AW = 12;
    localparam int VRAM_DW = 8;

    localparam logic [VRAM_DW-1:0] CH_BS = 8'h08;
    localparam logic [VRAM_DW-1:0] CH_LF = 8'h0A;
    localparam logic [VRAM_DW-1:0] CH_FF = 8'h0C;
    localparam logic [VRAM_DW-1:0] CH_CR = 8'h0D;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUT     = 3'd1,
        SCR_RD  = 3'd2,
        SCR_WR  = 3'd3,
        SCR_CLR = 3'd4,
        CLR_ALL = 3'd5
    } state_t;

    function automatic logic is_printable(input logic [VRAM_DW-1:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/vga_text_console_if.sv
// Byte stream into the console.
// Handshake: a byte transfers on every clock edge where ch_valid and
// ch_ready are both high; the producer holds ch stable while ch_valid is
// high and ch_ready is low, and may keep ch_valid high indefinitely.
//   master : byte producer (drives ch, ch_valid; sees ch_ready)
//   slave  : vga_text_console (sees ch, ch_valid; drives ch_ready)
interface vga_text_console_if;
    import vga_text_pkg::*;

    logic [VRAM_DW-1:0] ch;
    logic               ch_valid;
    logic               ch_ready;

    modport master (output ch, output ch_valid, input ch_ready);
    modport slave  (input ch, input ch_valid, output ch_ready);

endinterface

// File: rtl/vga_text_cursor.sv
// Hardware cursor: column/row counters plus the linear VRAM address
// (row*COLS + col) kept incrementally so no multiplier is needed.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset (cursor to 0,0)
//   inc                  advance one cell; wraps to column 0 at the right edge
//   cr, lf, bs, home     carriage return, line feed, backspace, go to 0,0
//   col, row, addr       registered cursor position and its VRAM address
//   at_right, at_bottom  cursor is on the last column / last row
// Only one command is expected per cycle; priority is home>inc>cr>lf>bs.
module vga_text_cursor
    import vga_text_pkg::*;
#(
    parameter int COLS = 80,
    parameter int ROWS = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               cr,
    input  logic               lf,
    input  logic               bs,
    input  logic               home,
    output logic [6:0]         col,
    output logic [4:0]         row,
    output logic [VRAM_AW-1:0] addr,
    output logic               at_right,
    output logic               at_bottom
);

    localparam logic [6:0]         LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]         LAST_ROW  = 5'(ROWS - 1);
    localparam logic [VRAM_AW-1:0] COLS_A    = VRAM_AW'(COLS);
    localparam logic [VRAM_AW-1:0] COLS_M1_A = VRAM_AW'(COLS - 1);

    logic [6:0]         col_q, col_d;
    logic [4:0]         row_q, row_d;
    logic [VRAM_AW-1:0] addr_q, addr_d;

    assign at_right  = (col_q == LAST_COL);
    assign at_bottom = (row_q == LAST_ROW);

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (home) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (inc) begin
            if (at_right) begin
                col_d = '0;
                if (at_bottom) begin
                    // Row stays put (the controller scrolls instead), so
                    // step back to the start of the same row.
                    addr_d = addr_q - COLS_M1_A;
                end else begin
                    row_d  = row_q + 5'd1;
                    addr_d = addr_q + 1'b1;
                end
            end else begin
                col_d  = col_q + 7'd1;
                addr_d = addr_q + 1'b1;
            end
        end else if (cr) begin
            col_d  = '0;
            addr_d = addr_q - {{(VRAM_AW-7){1'b0}}, col_q};
        end else if (lf) begin
            if (!at_bottom) begin
                row_d  = row_q + 5'd1;
                addr_d = addr_q + COLS_A;
            end
        end else if (bs) begin
            if (col_q != 7'd0) begin
                col_d  = col_q - 7'd1;
                addr_d = addr_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign addr = addr_q;

endmodule

// File: rtl/vga_text_console.sv
// Character-stream console controller owning the VRAM port of vga_text.
// Printable bytes are written at the cursor; CR, LF, BS and FF move the
// cursor or clear the screen; a line feed on the last row scrolls the
// screen up one row by copying VRAM and blanking the last row.
// Ports:
//   vclk, rst_n       clock (shared with vga_text), async active-low reset
//   chan              byte stream (slave side of vga_text_console_if)
//   vaddr/vdin/vwe    VRAM address, write data, write enable
//   vdout             VRAM read data, valid one cycle after a read address
//   cur_col, cur_row  cursor position
//   busy              high while clearing or scrolling
//   dbg_state         current controller state
module vga_text_console
    import vga_text_pkg::*;
#(
    parameter int                 COLS = 80,
    parameter int                 ROWS = 25,
    parameter logic [VRAM_DW-1:0] FILL = 8'h20
) (
    input  logic               vclk,
    input  logic               rst_n,
    vga_text_console_if.slave  chan,
    output logic [VRAM_AW-1:0] vaddr,
    output logic [VRAM_DW-1:0] vdin,
    output logic               vwe,
    input  logic [VRAM_DW-1:0] vdout,
    output logic [6:0]         cur_col,
    output logic [4:0]         cur_row,
    output logic               busy,
    output state_t             dbg_state
);

    localparam logic [VRAM_AW-1:0] COLS_A        = VRAM_AW'(COLS);
    localparam logic [VRAM_AW-1:0] LAST_CELL     = VRAM_AW'(COLS * ROWS - 1);
    localparam logic [VRAM_AW-1:0] LAST_ROW_BASE = VRAM_AW'((ROWS - 1) * COLS);

    state_t             state_q, state_d;
    logic [VRAM_AW-1:0] vaddr_q, vaddr_d;
    logic [VRAM_DW-1:0] vdin_q, vdin_d;
    logic               vwe_q, vwe_d;
    logic               ch_ready_q, ch_ready_d;
    logic               busy_q, busy_d;
    logic [VRAM_AW-1:0] src_q, src_d;
    logic [VRAM_AW-1:0] dst_q, dst_d;

    logic               accept;
    logic               go_scroll;
    logic               cur_inc, cur_cr, cur_lf, cur_bs, cur_home;
    logic [VRAM_AW-1:0] cur_addr;
    logic               cur_at_right, cur_at_bottom;

    vga_text_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk       (vclk),
        .rst_n     (rst_n),
        .inc       (cur_inc),
        .cr        (cur_cr),
        .lf        (cur_lf),
        .bs        (cur_bs),
        .home      (cur_home),
        .col       (cur_col),
        .row       (cur_row),
        .addr      (cur_addr),
        .at_right  (cur_at_right),
        .at_bottom (cur_at_bottom)
    );

    assign accept = chan.ch_valid && ch_ready_q && (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        vaddr_d   = vaddr_q;
        vdin_d    = vdin_q;
        vwe_d     = 1'b0;
        src_d     = src_q;
        dst_d     = dst_q;
        go_scroll = 1'b0;
        cur_inc   = 1'b0;
        cur_cr    = 1'b0;
        cur_lf    = 1'b0;
        cur_bs    = 1'b0;
        cur_home  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_printable(chan.ch)) begin
                        state_d = PUT;
                        vwe_d   = 1'b1;
                        vaddr_d = cur_addr;
                        vdin_d  = chan.ch;
                    end else begin
                        case (chan.ch)
                            CH_CR: cur_cr = 1'b1;
                            CH_LF: begin
                                if (cur_at_bottom) go_scroll = 1'b1;
                                else               cur_lf    = 1'b1;
                            end
                            CH_BS: cur_bs = 1'b1;
                            CH_FF: begin
                                cur_home = 1'b1;
                                state_d  = CLR_ALL;
                                vwe_d    = 1'b1;
                                vaddr_d  = '0;
                                vdin_d   = FILL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            PUT: begin
                cur_inc = 1'b1;
                if (cur_at_right && cur_at_bottom) go_scroll = 1'b1;
                else                               state_d   = IDLE;
            end
            SCR_RD: begin
                state_d = SCR_WR;
                vwe_d   = 1'b1;
                vaddr_d = dst_q;
            end
            SCR_WR: begin
                src_d = src_q + 1'b1;
                dst_d = dst_q + 1'b1;
                if (src_q == LAST_CELL) begin
                    state_d = SCR_CLR;
                    vwe_d   = 1'b1;
                    vaddr_d = LAST_ROW_BASE;
                    vdin_d  = FILL;
                end else begin
                    state_d = SCR_RD;
                    vaddr_d = src_q + 1'b1;
                end
            end
            SCR_CLR: begin
                if (vaddr_q == LAST_CELL) begin
                    state_d = IDLE;
                end else begin
                    vwe_d   = 1'b1;
                    vaddr_d = vaddr_q + 1'b1;
                end
            end
            CLR_ALL: begin
                vdin_d = FILL;
                // Coming out of reset no cell has been written yet (vwe low),
                // so the sweep starts at 0 instead of advancing.
                if (vwe_q && (vaddr_q == LAST_CELL)) begin
                    state_d = IDLE;
                end else begin
                    vwe_d   = 1'b1;
                    vaddr_d = vwe_q ? (vaddr_q + 1'b1) : '0;
                end
            end
            default: state_d = CLR_ALL;
        endcase

        if (go_scroll) begin
            state_d = SCR_RD;
            vwe_d   = 1'b0;
            vaddr_d = COLS_A;
            src_d   = COLS_A;
            dst_d   = '0;
        end

        busy_d     = (state_d == CLR_ALL) || (state_d == SCR_RD) ||
                     (state_d == SCR_WR)  || (state_d == SCR_CLR);
        // Ready drops for one cycle after every accepted byte.
        ch_ready_d = (state_d == IDLE) && !accept;
    end

    always_ff @(posedge vclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLR_ALL;
            vaddr_q    <= '0;
            vdin_q     <= '0;
            vwe_q      <= 1'b0;
            ch_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            src_q      <= '0;
            dst_q      <= '0;
        end else begin
            state_q    <= state_d;
            vaddr_q    <= vaddr_d;
            vdin_q     <= vdin_d;
            vwe_q      <= vwe_d;
            ch_ready_q <= ch_ready_d;
            busy_q     <= busy_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
        end
    end

    assign vaddr         = vaddr_q;
    // During a scroll write the data comes straight from the VRAM output
    // register; capturing it first would cost a third cycle per byte.
    assign vdin          = (state_q == SCR_WR) ? vdout : vdin_q;
    assign vwe           = vwe_q;
    assign chan.ch_ready = ch_ready_q;
    assign busy          = busy_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_vga_text_console.sv
module tb_vga_text_console;
    import vga_text_pkg::*;

    localparam int COLS  = 80;
    localparam int ROWS  = 25;
    localparam int CELLS = COLS * ROWS;
    localparam int LIMIT = 6000;

    // ---------------- clock / reset ----------------
    logic vclk  = 1'b0;
    logic rst_n = 1'b0;
    always #5 vclk = ~vclk;

    logic [11:0] vaddr;
    logic [7:0]  vdin;
    logic [7:0]  vdout;
    logic        vwe;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;
    state_t      dbg_state;

    vga_text_console_if chan();

    vga_text_console #(
        .COLS (COLS),
        .ROWS (ROWS),
        .FILL (8'h20)
    ) dut (
        .vclk      (vclk),
        .rst_n     (rst_n),
        .chan      (chan),
        .vaddr     (vaddr),
        .vdin      (vdin),
        .vwe       (vwe),
        .vdout     (vdout),
        .cur_col   (cur_col),
        .cur_row   (cur_row),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- VRAM model and monitors ----------------
    logic [7:0] mem [0:4095];
    logic       preload = 1'b0;
    int         cyc = 0;
    int         wr_cnt = 0;
    int         busy_cnt = 0;
    int         bad_addr_cnt = 0;

    always @(posedge vclk) begin
        cyc <= cyc + 1;
        if (vwe) begin
            mem[vaddr] <= vdin;
            wr_cnt     <= wr_cnt + 1;
            if (vaddr >= 12'd2000) bad_addr_cnt <= bad_addr_cnt + 1;
        end else if (preload) begin
            for (int i = 0; i < CELLS; i++) mem[i] <= 8'h30 + 8'(i / COLS);
        end
        vdout <= mem[vaddr];
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    // Presents b and waits for the cycle it is taken; t is the cycle count
    // at the negedge just before the accepting edge.
    task automatic send(input logic [7:0] b, output int t);
        int n;
        @(negedge vclk);
        chan.ch       = b;
        chan.ch_valid = 1'b1;
        n = 0;
        while (chan.ch_ready !== 1'b1 && n < LIMIT) begin
            @(negedge vclk);
            n++;
        end
        if (chan.ch_ready === 1'b1) begin
            t = cyc;
        end else begin
            n_checks++;
            $display("FAIL send_timeout: byte %02h not taken after %0d cycles", b, n);
            t = -1;
            chan.ch_valid = 1'b0;
        end
        @(posedge vclk);
    endtask

    task automatic idle_in();
        @(negedge vclk);
        chan.ch_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (chan.ch_ready !== 1'b1 && n < LIMIT) begin
            @(negedge vclk);
            n++;
        end
        if (chan.ch_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL ready_timeout: ch_ready still %b after %0d cycles", chan.ch_ready, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int w0, bad;
        rst_n = 1'b0;
        chan.ch = 8'h00;
        chan.ch_valid = 1'b0;
        repeat (3) @(negedge vclk);
        n_checks++; if (vaddr !== 12'd0) $display("FAIL rst_vaddr: got %0d expected 0", vaddr); else n_pass++;
        n_checks++; if (vdin !== 8'h00) $display("FAIL rst_vdin: got %02h expected 00", vdin); else n_pass++;
        n_checks++; if (vwe !== 1'b0) $display("FAIL rst_vwe: got %b expected 0", vwe); else n_pass++;
        n_checks++; if (chan.ch_ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", chan.ch_ready); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL rst_busy: got %b expected 1", busy); else n_pass++;
        n_checks++; if (cur_col !== 7'd0) $display("FAIL rst_col: got %0d expected 0", cur_col); else n_pass++;
        n_checks++; if (cur_row !== 5'd0) $display("FAIL rst_row: got %0d expected 0", cur_row); else n_pass++;
        n_checks++; if (dbg_state !== CLR_ALL) $display("FAIL rst_state: got %0d expected %0d", dbg_state, CLR_ALL); else n_pass++;
        w0 = wr_cnt;
        rst_n = 1'b1;
        @(negedge vclk);
        n_checks++; if (chan.ch_ready !== 1'b0) $display("FAIL clr_ready_low: got %b expected 0", chan.ch_ready); else n_pass++;
        wait_ready();
        n_checks++; if (wr_cnt - w0 !== 2000) $display("FAIL clr_writes: got %0d expected 2000", wr_cnt - w0); else n_pass++;
        bad = 0;
        for (int i = 0; i < CELLS; i++) if (mem[i] !== 8'h20) bad++;
        n_checks++; if (bad !== 0) $display("FAIL clr_cells: %0d cells not 20, expected 0", bad); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL clr_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (cur_col !== 7'd0 || cur_row !== 5'd0)
            $display("FAIL clr_cursor: got (%0d,%0d) expected (0,0)", cur_col, cur_row); else n_pass++;
    endtask

    task automatic test_put_ab();
        int t1, t2;
        send(8'h41, t1);
        send(8'h42, t2);
        idle_in();
        repeat (2) @(negedge vclk);
        n_checks++; if (mem[0] !== 8'h41) $display("FAIL ab_vram0: got %02h expected 41", mem[0]); else n_pass++;
        n_checks++; if (mem[1] !== 8'h42) $display("FAIL ab_vram1: got %02h expected 42", mem[1]); else n_pass++;
        n_checks++; if (cur_col !== 7'd2) $display("FAIL ab_col: got %0d expected 2", cur_col); else n_pass++;
        n_checks++; if (cur_row !== 5'd0) $display("FAIL ab_row: got %0d expected 0", cur_row); else n_pass++;
        n_checks++; if (t2 - t1 !== 2) $display("FAIL ab_spacing: got %0d cycles expected 2", t2 - t1); else n_pass++;
    endtask

    task automatic test_wrap();
        int t, bad;
        send(CH_CR, t);
        for (int i = 0; i < COLS; i++) send(8'h78, t);
        send(8'h79, t);
        idle_in();
        repeat (2) @(negedge vclk);
        bad = 0;
        for (int c = 0; c < COLS; c++) if (mem[c] !== 8'h78) bad++;
        n_checks++; if (bad !== 0) $display("FAIL wrap_row0: %0d cells not 78, expected 0", bad); else n_pass++;
        n_checks++; if (mem[80] !== 8'h79) $display("FAIL wrap_vram80: got %02h expected 79", mem[80]); else n_pass++;
        n_checks++; if (cur_col !== 7'd1 || cur_row !== 5'd1)
            $display("FAIL wrap_cursor: got (%0d,%0d) expected (1,1)", cur_col, cur_row); else n_pass++;
    endtask

    task automatic test_scroll();
        int t, t1, t2, w0, bad0, bad12, bad23, bad24;
        for (int i = 0; i < 23; i++) send(CH_LF, t);
        idle_in();
        n_checks++; if (cur_col !== 7'd1 || cur_row !== 5'd24)
            $display("FAIL lf_cursor: got (%0d,%0d) expected (1,24)", cur_col, cur_row); else n_pass++;
        @(negedge vclk); preload = 1'b1;
        @(negedge vclk); preload = 1'b0;
        w0 = wr_cnt;
        send(CH_LF, t1);
        send(8'h07, t2);
        idle_in();
        repeat (2) @(negedge vclk);
        n_checks++; if (t2 - t1 !== 3921) $display("FAIL scr_latency: got %0d cycles expected 3921", t2 - t1); else n_pass++;
        n_checks++; if (wr_cnt - w0 !== 2000) $display("FAIL scr_writes: got %0d expected 2000", wr_cnt - w0); else n_pass++;
        bad0 = 0; bad12 = 0; bad23 = 0; bad24 = 0;
        for (int c = 0; c < COLS; c++) begin
            if (mem[c] !== 8'h31) bad0++;
            if (mem[12 * COLS + c] !== 8'h3D) bad12++;
            if (mem[23 * COLS + c] !== 8'h48) bad23++;
            if (mem[24 * COLS + c] !== 8'h20) bad24++;
        end
        n_checks++; if (bad0 !== 0) $display("FAIL scr_row0: %0d cells not 31, expected 0", bad0); else n_pass++;
        n_checks++; if (bad12 !== 0) $display("FAIL scr_row12: %0d cells not 3D, expected 0", bad12); else n_pass++;
        n_checks++; if (bad23 !== 0) $display("FAIL scr_row23: %0d cells not 48, expected 0", bad23); else n_pass++;
        n_checks++; if (bad24 !== 0) $display("FAIL scr_row24: %0d cells not 20, expected 0", bad24); else n_pass++;
        n_checks++; if (cur_col !== 7'd1 || cur_row !== 5'd24)
            $display("FAIL scr_cursor: got (%0d,%0d) expected (1,24)", cur_col, cur_row); else n_pass++;
    endtask

    task automatic test_controls();
        int t, w0;
        send(CH_CR, t);
        send(CH_BS, t);
        idle_in();
        n_checks++; if (cur_col !== 7'd0 || cur_row !== 5'd24)
            $display("FAIL bs_at_col0: got (%0d,%0d) expected (0,24)", cur_col, cur_row); else n_pass++;
        send(8'h5A, t);
        idle_in();
        repeat (2) @(negedge vclk);
        n_checks++; if (mem[1920] !== 8'h5A) $display("FAIL cr_z_vram: got %02h expected 5A", mem[1920]); else n_pass++;
        n_checks++; if (cur_col !== 7'd1) $display("FAIL cr_z_col: got %0d expected 1", cur_col); else n_pass++;
        send(CH_BS, t);
        idle_in();
        n_checks++; if (cur_col !== 7'd0) $display("FAIL bs_step: got %0d expected 0", cur_col); else n_pass++;
        w0 = wr_cnt;
        send(8'h07, t);
        idle_in();
        repeat (3) @(negedge vclk);
        n_checks++; if (wr_cnt - w0 !== 0) $display("FAIL drop_writes: got %0d expected 0", wr_cnt - w0); else n_pass++;
        n_checks++; if (cur_col !== 7'd0 || cur_row !== 5'd24)
            $display("FAIL drop_cursor: got (%0d,%0d) expected (0,24)", cur_col, cur_row); else n_pass++;
        n_checks++; if (chan.ch_ready !== 1'b1) $display("FAIL drop_ready: got %b expected 1", chan.ch_ready); else n_pass++;
    endtask

    task automatic test_ff();
        int t, t1, t2, w0, b0, bad;
        send(CH_FF, t);
        idle_in();
        wait_ready();
        for (int i = 0; i < 10; i++) send(CH_LF, t);
        for (int i = 0; i < 5; i++) send(8'h6B, t);
        idle_in();
        repeat (2) @(negedge vclk);
        n_checks++; if (cur_col !== 7'd5 || cur_row !== 5'd10)
            $display("FAIL ff_setup: got (%0d,%0d) expected (5,10)", cur_col, cur_row); else n_pass++;
        n_checks++; if (mem[804] !== 8'h6B) $display("FAIL ff_setup_vram: got %02h expected 6B", mem[804]); else n_pass++;
        w0 = wr_cnt;
        b0 = busy_cnt;
        send(CH_FF, t1);
        send(8'h07, t2);
        idle_in();
        repeat (2) @(negedge vclk);
        n_checks++; if (t2 - t1 !== 2001) $display("FAIL ff_latency: got %0d cycles expected 2001", t2 - t1); else n_pass++;
        n_checks++; if (wr_cnt - w0 !== 2000) $display("FAIL ff_writes: got %0d expected 2000", wr_cnt - w0); else n_pass++;
        n_checks++; if (busy_cnt - b0 !== 2000) $display("FAIL ff_busy: got %0d cycles expected 2000", busy_cnt - b0); else n_pass++;
        n_checks++; if (cur_col !== 7'd0 || cur_row !== 5'd0)
            $display("FAIL ff_cursor: got (%0d,%0d) expected (0,0)", cur_col, cur_row); else n_pass++;
        bad = 0;
        for (int i = 0; i < CELLS; i++) if (mem[i] !== 8'h20) bad++;
        n_checks++; if (bad !== 0) $display("FAIL ff_cells: %0d cells not 20, expected 0", bad); else n_pass++;
    endtask

    task automatic test_reset_mid_scroll();
        int t, w0, bad;
        for (int i = 0; i < 24; i++) send(CH_LF, t);
        send(CH_LF, t);
        idle_in();
        // 101 cycles after the accepting edge the copy is in a write cycle.
        repeat (101) @(negedge vclk);
        n_checks++; if (busy !== 1'b1 || vwe !== 1'b1)
            $display("FAIL mid_pre: busy=%b vwe=%b expected 1 1", busy, vwe); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (vwe !== 1'b0) $display("FAIL mid_vwe_async: got %b expected 0", vwe); else n_pass++;
        n_checks++; if (chan.ch_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL mid_rst_flags: ready=%b busy=%b expected 0 1", chan.ch_ready, busy); else n_pass++;
        n_checks++; if (cur_col !== 7'd0 || cur_row !== 5'd0)
            $display("FAIL mid_rst_cursor: got (%0d,%0d) expected (0,0)", cur_col, cur_row); else n_pass++;
        repeat (3) @(negedge vclk);
        rst_n = 1'b1;
        w0 = wr_cnt;
        @(negedge vclk);
        n_checks++; if (dbg_state !== CLR_ALL) $display("FAIL mid_restart_state: got %0d expected %0d", dbg_state, CLR_ALL); else n_pass++;
        wait_ready();
        n_checks++; if (wr_cnt - w0 !== 2000) $display("FAIL mid_clr_writes: got %0d expected 2000", wr_cnt - w0); else n_pass++;
        bad = 0;
        for (int i = 0; i < CELLS; i++) if (mem[i] !== 8'h20) bad++;
        n_checks++; if (bad !== 0) $display("FAIL mid_clr_cells: %0d cells not 20, expected 0", bad); else n_pass++;
        n_checks++; if (bad_addr_cnt !== 0) $display("FAIL addr_range: %0d writes at or above 2000, expected 0", bad_addr_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_put_ab();
        test_wrap();
        test_scroll();
        test_controls();
        test_ff();
        test_reset_mid_scroll();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_text_console.md
Name: vga_text_console

Overview:
- Character-stream controller that owns the video RAM port of vga_text.
- Accepts bytes over a valid/ready handshake and writes printable characters at a hardware cursor.
- Interprets CR, LF, BS and FF, and scrolls the screen up by one row via read-modify-write of VRAM.
- Sits between any byte producer (UART RX, CPU register, test ROM) and vga_text; vga_text's addr/din/we/dout are driven only by this block.

Parameters:
- COLS, 80: characters per row.
- ROWS, 25: rows per screen. COLS*ROWS must be ≤ 4096.
- FILL, 8'h20: byte written when clearing cells.

Ports:
- vclk  in  1: system/pixel clock, same clock as vga_text.
- rst_n  in  1: asynchronous active-low reset.
- ch  in  8: input byte.
- ch_valid  in  1: ch is valid this cycle.
- ch_ready  out  1: block accepts ch this cycle.
- vaddr  out  12: VRAM address, connects to vga_text addr.
- vdin  out  8: VRAM write data, connects to vga_text din.
- vwe  out  1: VRAM write enable, connects to vga_text we.
- vdout  in  8: VRAM read data from vga_text dout. Valid one cycle after vaddr is presented with vwe=0.
- cur_col  out  7: cursor column, 0..COLS-1.
- cur_row  out  5: cursor row, 0..ROWS-1.
- busy  out  1: high while clearing or scrolling.

Behaviour:
- Reset is asynchronous, active-low. All outputs are registered.
- Reset values: vaddr=0, vdin=0, vwe=0, ch_ready=0, cur_col=0, cur_row=0, busy=1. The FSM enters CLR_ALL.
- Addressing: address = row*COLS + col. Compute it with an incrementing pointer or adder, not a multiplier.
- Handshake: a byte is accepted on a cycle with ch_valid&ch_ready. ch_ready=1 only in IDLE, and it drops the cycle after acceptance.
- FSM states and transitions:
  - IDLE: ch_ready=1, busy=0, vwe=0. On accept, decode ch:
    - 8'h20..8'h7E: go to PUT.
    - 8'h0D (CR): cur_col←0, stay in IDLE. ch_ready returns 1 after one cycle.
    - 8'h0A (LF): if cur_row<ROWS-1, cur_row++ and stay in IDLE; else go to SCR_RD with src=COLS, dst=0.
    - 8'h08 (BS): if cur_col>0, cur_col--; otherwise no effect. Never moves to the previous row.
    - 8'h0C (FF): go to CLR_ALL and reset the cursor to 0,0.
    - Any other byte: silently dropped.
  - PUT:
    - One cycle with vwe=1, vaddr=cursor address, vdin=ch.
    - Then cur_col++. If cur_col was COLS-1: cur_col←0 and perform the LF rule, either cur_row++ or go to SCR_RD.
    - Otherwise return to IDLE.
  - SCR_RD: vwe=0, vaddr=src. Next state is SCR_WR.
  - SCR_WR:
    - vwe=1, vaddr=dst, vdin=vdout. Then src++ and dst++.
    - If src was COLS*ROWS-1, go to SCR_CLR with ptr=(ROWS-1)*COLS; else go back to SCR_RD.
    - Each byte copy takes exactly 2 cycles.
  - SCR_CLR:
    - vwe=1, vaddr=ptr, vdin=FILL, ptr++, for COLS cycles.
    - Then go to IDLE; cur_row stays at ROWS-1.
  - CLR_ALL:
    - vwe=1, vdin=FILL, vaddr from 0 to COLS*ROWS-1, one cell per cycle.
    - Then go to IDLE.
- busy=1 in CLR_ALL, SCR_RD, SCR_WR and SCR_CLR.
- Latencies (80x25 defaults):
  - Printable char: 2 cycles from accept to ch_ready=1.
  - Scroll: 2*(ROWS-1)*COLS + COLS + 1 = 3921 cycles.
  - Full clear: COLS*ROWS = 2000 cycles.
- vwe is never asserted for an address ≥ COLS*ROWS.
- rst_n asserted mid-scroll or mid-clear aborts immediately. vwe drops asynchronously, and the FSM restarts with CLR_ALL after release.
- ch_valid may stay high continuously. Exactly one byte is consumed per ch_ready=1 cycle.

Decomposition:
- Shared package vga_text_pkg holds:
  - Control codes CH_BS, CH_LF, CH_FF, CH_CR.
  - The state enum.
  - VRAM_AW=12 and VRAM_DW=8.
- One natural sub-module: vga_text_cursor.
  - Holds the col/row counters and the linear address pointer.
  - Inputs: inc, cr, lf, bs, home.
  - Outputs: wrap/at-bottom flags.
  - The controller FSM consumes those flags.

Test Plan:
- Reset release: ch_ready=0 and busy=1 for 2000 cycles; VRAM model shows all 2000 cells = 8'h20; then ch_ready=1 and cursor (0,0).
- Send "A","B": VRAM[0]=8'h41, VRAM[1]=8'h42; cur_col=2; each char accepted 2 cycles apart with ch_valid held high.
- Send 80 × "x", then "y": row 0 is full of 8'h78; VRAM[80]=8'h79; cursor (1,1).
- Preload row r with byte r+8'h30 for rows 0..24, place cursor at row 24, send LF:
  - busy for 3921 cycles.
  - Afterwards, row 0 contains 8'h31, row 23 contains 8'h48, row 24 contains 8'h20.
  - Cursor stays at (col, 24).
- BS at col 0 leaves the cursor unchanged. CR then "Z" writes to VRAM[row*80]. Byte 8'h07 is accepted with no VRAM write.
- FF at cursor (5,10): 2000 clear cycles, then cursor (0,0). Assert rst_n low mid-scroll: vwe=0 immediately, and CLR_ALL restarts after release.
